hilo_mac_unit: RTL and testbench
================================

# hilo_mac_unit

Parametrised successor to the HI/LO register for the pipeline's multiply/divide path. It holds a 2×XLEN HI/LO pair and accepts four kinds of request: full-pair writes, HI-only writes, LO-only writes, and the MIPS multiply-accumulate family (MADD/MADDU/MSUB/MSUBU). Accumulates run through a registered two-stage pipeline that can be flushed. A valid/ready handshake stalls issue while an accumulate is in flight, and a read port serves MFHI/MFLO with a hazard flag.

## Interface
Parameters:
- XLEN, 32, width of each of HI and LO; pair width is 2*XLEN.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present this cycle.
- req_ready  out  1  unit can accept a request this cycle.
- req_op  in  3  operation code, encodings in hilo_pkg.
- req_wdata  in  2*XLEN  write data: [2XLEN-1:XLEN] goes to HI, [XLEN-1:0] goes to LO.
- req_a  in  XLEN  accumulate operand A.
- req_b  in  XLEN  accumulate operand B.
- flush  in  1  cancel any uncommitted accumulate; block acceptance this cycle.
- rd_sel  in  1  read select: 1 = HI, 0 = LO.
- rd_data  out  XLEN  selected register.
- rd_valid  out  1  rd_data is architecturally current.
- hi_o  out  XLEN  current HI.
- lo_o  out  XLEN  current LO.

## Operation
- Op encodings:
  - 000 WR_BOTH, 001 WR_HI, 010 WR_LO.
  - 011 reserved; accepted and treated as a no-op.
  - 100 MADD, 101 MADDU, 110 MSUB, 111 MSUBU.
- Acceptance: a request is accepted when req_valid && req_ready.
- req_ready = ~busy & ~flush & ~rst.
- Writes:
  - WR_BOTH loads the full pair.
  - WR_HI loads HI only; LO is held.
  - WR_LO loads LO only; HI is held.
- Accumulate ops:
  - Stage 1 registers the 2*XLEN product into prod_q and sets busy.
  - Signed ops (MADD, MSUB) use sign-extended a×b.
  - Unsigned ops (MADDU, MSUBU) use zero-extended a×b.
  - Stage 2 computes {HI,LO} ± prod_q modulo 2^(2XLEN), with no saturation, and commits it to HI/LO.
  - MADD and MADDU add; MSUB and MSUBU subtract.
  - busy clears at the same edge as the commit.
- State machine:
  - IDLE → MUL on an accepted accumulate.
  - MUL → IDLE on the next edge, either with commit or, if flush was high in the MUL cycle, with product discarded and HI/LO unchanged.
- Flush in IDLE has no effect on HI/LO but still forces req_ready low that cycle.
- Read port:
  - rd_data = rd_sel ? HI : LO, combinational from registered state.
  - rd_valid = ~busy.
  - No same-cycle forwarding of an accepted write: a read in the accept cycle returns the old value with rd_valid=1.
  - The pipeline must stall MFHI/MFLO on rd_valid=0.
- Reset: HI=0, LO=0, busy=0, prod_q=0. This applies in any state, including mid-accumulate; the in-flight product is discarded.

## Timing
- Write latency: 1 cycle. A write accepted in cycle N is visible on hi_o/lo_o/rd_data in cycle N+1.
- Accumulate latency: 2 cycles. An accumulate accepted in cycle N sets busy in N+1 (req_ready=0, rd_valid=0), and the result is visible in N+2.
- Throughput:
  - One write per cycle.
  - One accumulate per 2 cycles.
  - A write may be accepted in N+2, right behind an accumulate.
- Outputs during and immediately after reset:
  - req_ready=0 while rst is high.
  - In the first cycle after rst drops: req_ready=1, rd_valid=1, hi_o=lo_o=rd_data=0.
- Simultaneous events:
  - flush with req_valid: the request is not accepted, and the requester must hold it.
  - flush with stage-2 commit: flush wins, and nothing is committed.

## Structure
- hilo_pkg holds:
  - The op-code localparams OP_WR_BOTH through OP_MSUBU.
  - A helper function op_is_mac (op[2]).
  - A helper function op_is_signed (~op[0]), applied only to MAC ops.
  - The default XLEN.
- Sub-module hilo_mul_stage: registered XLEN×XLEN multiplier with signed/unsigned select, a valid-in/valid-out pair, and flush and rst inputs. It owns prod_q and busy.
- The top level owns HI/LO, the stage-2 add/subtract and commit, the handshake and the read mux.

## Test plan
All scenarios use XLEN=32.
- Reset, then WR_BOTH with wdata=0x11223344_55667788 → next cycle hi_o=0x11223344, lo_o=0x55667788, and rd_sel=1 gives rd_data=0x11223344.
- From the state above, WR_HI with wdata=0xAAAAAAAA_00000000 → hi_o=0xAAAAAAAA and lo_o stays 0x55667788. Then WR_LO with wdata=0x0000_0000_0000_0001 → lo_o=1 and hi_o unchanged.
- HI/LO=0, MADD a=0xFFFFFFFE, b=3 → cycle N+1 has req_ready=0 and rd_valid=0; cycle N+2 has hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFA, req_ready=1.
- HI/LO=0, MADDU a=0xFFFFFFFE, b=3 → N+2 has hi_o=0x00000002, lo_o=0xFFFFFFFA. Then MSUBU a=0xFFFFFFFE, b=3 → HI/LO=0.
- HI/LO=0, MSUB a=1, b=1 → HI/LO wraps to 0xFFFFFFFF_FFFFFFFF.
- Flush and reset cases:
  - Accumulate accepted, then flush in N+1 → HI/LO unchanged in N+2, and req_ready=1 in N+2.
  - Separately, assert rst in N+1 → in the cycle after rst drops, HI/LO=0 and busy=0.
  - flush asserted together with req_valid → the request is not accepted.

Source files
------------

// File: rtl/hilo_pkg.sv
// Shared op-codes, default width and op-decode helpers for the HI/LO MAC unit.
package hilo_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] OP_WR_BOTH = 3'b000;
  localparam logic [2:0] OP_WR_HI   = 3'b001;
  localparam logic [2:0] OP_WR_LO   = 3'b010;
  localparam logic [2:0] OP_RSVD    = 3'b011;
  localparam logic [2:0] OP_MADD    = 3'b100;
  localparam logic [2:0] OP_MADDU   = 3'b101;
  localparam logic [2:0] OP_MSUB    = 3'b110;
  localparam logic [2:0] OP_MSUBU   = 3'b111;

  function automatic logic op_is_mac(input logic [2:0] op);
    return (op & 3'b100) != 3'b000;
  endfunction

  // Only meaningful for MAC ops: even encodings are the signed variants.
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op & 3'b001) == 3'b000;
  endfunction

endpackage

// File: rtl/hilo_mul_stage.sv
// Stage 1 of the accumulate path: registered XLENxXLEN multiply, owns prod_q and busy.
module hilo_mul_stage
  import hilo_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              is_signed,
  input  logic              flush,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [2*XLEN-1:0] prod_q,
  output logic              busy,
  output logic              out_valid
);

  localparam int unsigned PW = 2 * XLEN;

  typedef enum logic {IDLE, MUL} state_t;

  state_t        state;
  logic [PW-1:0] a_ext;
  logic [PW-1:0] b_ext;
  logic [PW-1:0] prod;

  // Extending both operands to the pair width makes the truncated product exact for either signedness.
  always_comb begin
    a_ext = is_signed ? {{XLEN{a[XLEN-1]}}, a} : {{XLEN{1'b0}}, a};
    b_ext = is_signed ? {{XLEN{b[XLEN-1]}}, b} : {{XLEN{1'b0}}, b};
    prod  = a_ext * b_ext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      prod_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && !flush) begin
            prod_q <= prod;
            state  <= MUL;
          end
        end
        MUL:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state == MUL);
  // A flush in the MUL cycle drops the product instead of presenting it for commit.
  assign out_valid = busy & ~flush;

endmodule

// File: rtl/hilo_mac_unit.sv
// HI/LO register pair with direct writes, two-stage multiply-accumulate and MFHI/MFLO read port.
module hilo_mac_unit
  import hilo_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [2*XLEN-1:0] req_wdata,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  input  logic              flush,
  input  logic              rd_sel,
  output logic [XLEN-1:0]   rd_data,
  output logic              rd_valid,
  output logic [XLEN-1:0]   hi_o,
  output logic [XLEN-1:0]   lo_o
);

  localparam int unsigned PW = 2 * XLEN;

  logic [XLEN-1:0] hi_q;
  logic [XLEN-1:0] lo_q;
  logic            sub_q;
  logic [PW-1:0]   prod_q;
  logic            busy;
  logic            commit;
  logic            accept;
  logic [PW-1:0]   acc_next;

  assign req_ready = ~busy & ~flush & ~rst;
  assign accept    = req_valid & req_ready;

  hilo_mul_stage #(.XLEN(XLEN)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (accept & op_is_mac(req_op)),
    .is_signed (op_is_signed(req_op)),
    .flush     (flush),
    .a         (req_a),
    .b         (req_b),
    .prod_q    (prod_q),
    .busy      (busy),
    .out_valid (commit)
  );

  // Stage 2: wrap-around add/subtract of the registered product into the pair.
  assign acc_next = sub_q ? ({hi_q, lo_q} - prod_q) : ({hi_q, lo_q} + prod_q);

  // Commit and accept are mutually exclusive because busy blocks req_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      sub_q <= 1'b0;
    end else if (commit) begin
      {hi_q, lo_q} <= acc_next;
    end else if (accept) begin
      case (req_op)
        OP_WR_BOTH: begin
          hi_q <= req_wdata[PW-1:XLEN];
          lo_q <= req_wdata[XLEN-1:0];
        end
        OP_WR_HI: hi_q  <= req_wdata[PW-1:XLEN];
        OP_WR_LO: lo_q  <= req_wdata[XLEN-1:0];
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: sub_q <= req_op[1];
        default: ;
      endcase
    end
  end

  assign rd_data  = rd_sel ? hi_q : lo_q;
  assign rd_valid = ~busy;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

// File: tb/tb_hilo_mac_unit.sv
// Randomized scoreboard bench for hilo_mac_unit against a pair-arithmetic reference model.
`timescale 1ns/1ps
module tb_hilo_mac_unit;

  localparam int unsigned XLEN = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [2*XLEN-1:0] req_wdata;
  logic [XLEN-1:0]   req_a;
  logic [XLEN-1:0]   req_b;
  logic              flush;
  logic              rd_sel;
  logic [XLEN-1:0]   rd_data;
  logic              rd_valid;
  logic [XLEN-1:0]   hi_o;
  logic [XLEN-1:0]   lo_o;

  hilo_mac_unit #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_wdata (req_wdata),
    .req_a     (req_a),
    .req_b     (req_b),
    .flush     (flush),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [63:0] pair;
    logic        rdv;
    logic        rdy;
    logic        sel;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference state: the architectural pair plus an accumulate result waiting to land.
  logic [63:0] m_pair;
  logic        m_busy;
  logic [63:0] m_pend;

  function automatic logic [63:0] mac_ref(input logic [63:0] pair, input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    if (op[0] == 1'b0) p = 64'(longint'(signed'(a)) * longint'(signed'(b)));
    else               p = 64'(a) * 64'(b);
    return op[1] ? pair - p : pair + p;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp_v);
    end
  endtask

  // Monitor: whenever the DUT presents a cycle with a pending expectation, pop and compare.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      exp_t s;
      s = q.pop_front();
      check("stale_expectation", 64'(s.due), 64'(cyc));
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      exp_t e;
      e = q.pop_front();
      check("hi_o",      64'(hi_o),      64'(e.pair[63:32]));
      check("lo_o",      64'(lo_o),      64'(e.pair[31:0]));
      check("rd_data",   64'(rd_data),   64'(e.sel ? e.pair[63:32] : e.pair[31:0]));
      check("rd_valid",  64'(rd_valid),  64'(e.rdv));
      check("req_ready", 64'(req_ready), 64'(e.rdy));
    end
  end

  // Drive one cycle, record what the DUT must show in it, then advance the reference.
  task automatic step(input logic r, input logic v, input logic [2:0] op, input logic [63:0] wd,
                      input logic [31:0] a, input logic [31:0] b, input logic fl, input logic sel);
    exp_t e;
    logic acc;
    @(posedge clk);
    #1;
    rst = r; req_valid = v; req_op = op; req_wdata = wd;
    req_a = a; req_b = b; flush = fl; rd_sel = sel;
    e.due  = cyc;
    e.pair = m_pair;
    e.rdv  = ~m_busy;
    e.rdy  = ~m_busy & ~fl & ~r;
    e.sel  = sel;
    q.push_back(e);
    acc = v & e.rdy;
    if (r) begin
      m_pair = '0;
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (!fl) m_pair = m_pend;
      m_busy = 1'b0;
    end else if (acc) begin
      case (op)
        3'b000: m_pair = wd;
        3'b001: m_pair[63:32] = wd[63:32];
        3'b010: m_pair[31:0]  = wd[31:0];
        3'b011: ;
        default: begin
          m_pend = mac_ref(m_pair, op, a, b);
          m_busy = 1'b1;
        end
      endcase
    end
  endtask

  task automatic idle(input logic sel);
    step(1'b0, 1'b0, 3'b000, 64'h0, 32'h0, 32'h0, 1'b0, sel);
  endtask

  task automatic req(input logic [2:0] op, input logic [63:0] wd,
                     input logic [31:0] a, input logic [31:0] b);
    step(1'b0, 1'b1, op, wd, a, b, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_wdata = '0;
    req_a = '0; req_b = '0; flush = 1'b0; rd_sel = 1'b0;
    m_pair = '0; m_busy = 1'b0; m_pend = '0;
    repeat (2) @(posedge clk);
    step(1'b1, 1'b0, 3'b000, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1'b0);

    // Directed writes
    req(3'b000, 64'h11223344_55667788, 32'h0, 32'h0);
    idle(1'b1);
    req(3'b001, 64'hAAAAAAAA_00000000, 32'h0, 32'h0);
    idle(1'b0);
    req(3'b010, 64'h00000000_00000001, 32'h0, 32'h0);
    idle(1'b1);
    req(3'b011, 64'hDEADBEEF_DEADBEEF, 32'h0, 32'h0);
    idle(1'b0);

    // Accumulates from zero
    req(3'b000, 64'h0, 32'h0, 32'h0);
    req(3'b100, 64'h0, 32'hFFFFFFFE, 32'd3);
    idle(1'b1); idle(1'b0);
    req(3'b000, 64'h0, 32'h0, 32'h0);
    req(3'b101, 64'h0, 32'hFFFFFFFE, 32'd3);
    idle(1'b1); idle(1'b1);
    req(3'b111, 64'h0, 32'hFFFFFFFE, 32'd3);
    idle(1'b0); idle(1'b0);
    req(3'b110, 64'h0, 32'd1, 32'd1);
    idle(1'b1); idle(1'b0);

    // Write right behind an accumulate
    req(3'b100, 64'h0, 32'd7, 32'd9);
    idle(1'b1);
    req(3'b000, 64'h01020304_05060708, 32'h0, 32'h0);
    idle(1'b1);

    // Flush in the MUL cycle discards the product
    req(3'b101, 64'h0, 32'h12345678, 32'h9ABCDEF0);
    step(1'b0, 1'b0, 3'b000, 64'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    idle(1'b1);

    // Flush alongside a request blocks acceptance
    step(1'b0, 1'b1, 3'b000, 64'hFFFF0000_FFFF0000, 32'h0, 32'h0, 1'b1, 1'b1);
    idle(1'b1);

    // Reset mid-accumulate
    req(3'b100, 64'h0, 32'h00001000, 32'h00002000);
    step(1'b1, 1'b0, 3'b000, 64'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    idle(1'b1); idle(1'b0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [63:0] wd;
      wd = {$urandom, $urandom};
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), wd, $urandom, $urandom,
           ($urandom_range(0, 7) == 0), 1'($urandom));
    end
    idle(1'b0); idle(1'b1);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain_timeout left=%0d want=0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
